// File: rtl/enc2_pkg.sv
// Shared widths, packet field offsets, LFSR taps and mask expansion for the
// masked-add cipher (common to the encrypt and decrypt sides).
package enc2_pkg;

  localparam int PT_W  = 60;
  localparam int KEY_W = 11;
  localparam int Y_W   = 61;
  localparam int PKT_W = 78;
  localparam int HDR_W = 6;

  // packet = {hdr, y, key}
  localparam int KEY_LSB = 0;
  localparam int Y_LSB   = KEY_LSB + KEY_W;
  localparam int HDR_LSB = Y_LSB + Y_W;

  // x^11 + x^9 + 1
  localparam int TAP_HI = 10;
  localparam int TAP_LO = 8;

  localparam logic [KEY_W-1:0] LFSR_SEED_DEF = 11'h7FF;

  function automatic logic [PT_W-1:0] enc2_mask(
    input logic [KEY_W-1:0] r
  );
    return {r, r, ~r, ~r, r, r[10:6]};
  endfunction

endpackage

// File: rtl/enc2_key_lfsr.sv
// 11-bit Fibonacci key LFSR with seed load (zero replaced by SEED).
// Ports: Clk, Rst, adv (step), load/load_val (reseed, wins over adv), key.
module enc2_key_lfsr
  import enc2_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             adv,
  input  logic             load,
  input  logic [KEY_W-1:0] load_val,
  output logic [KEY_W-1:0] key
);

  logic [KEY_W-1:0] r_q;
  logic [KEY_W-1:0] r_step;
  logic [KEY_W-1:0] r_seed;

  assign r_step = {r_q[KEY_W-2:0], r_q[TAP_HI] ^ r_q[TAP_LO]};
  // an all-zero state would lock the LFSR
  assign r_seed = (load_val == '0) ? SEED : load_val;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= r_seed;
    end else if (adv) begin
      r_q <= r_step;
    end
  end

  assign key = r_q;

endmodule

// File: rtl/encrypt_function_2.sv
// Masked-add encryptor: 60-bit plaintext -> 78-bit {hdr, y, key} packet,
// 2-stage valid/ready pipeline. Ports: Clk, Rst, in_valid/in_ready/in_data,
// seed_load/seed_val, out_valid/out_ready/out_data.
// Define ENC2_SEQ_TAG_EN to put a 6-bit wrapping sequence tag in the header.
module encrypt_function_2
  import enc2_pkg::*;
#(
  parameter logic [KEY_W-1:0] LFSR_SEED = 11'h7FF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PT_W-1:0]  in_data,
  input  logic             seed_load,
  input  logic [KEY_W-1:0] seed_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data
);

  logic             s1_valid;
  logic [PT_W-1:0]  s1_p;
  logic [KEY_W-1:0] s1_r;
  logic             s2_load;
  logic             accept;
  logic [KEY_W-1:0] key;
  logic [PT_W-1:0]  mask_b;
  logic [Y_W-1:0]   y;
  logic [HDR_W-1:0] hdr;
  logic [PKT_W-1:0] pkt;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  enc2_key_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Rst     (Rst),
    .adv     (accept),
    .load    (seed_load),
    .load_val(seed_val),
    .key     (key)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_r     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_p     <= in_data;
      s1_r     <= key;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  assign mask_b = enc2_mask(s1_r);
  // carry is kept in y[60]; the decryptor needs it
  assign y = {1'b0, s1_p} + {1'b0, mask_b};

`ifdef ENC2_SEQ_TAG_EN
  logic [HDR_W-1:0] seq_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      seq_q <= '0;
    end else if (s2_load && s1_valid) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  assign hdr = seq_q;
`else
  assign hdr = '0;
`endif

  always_comb begin
    pkt = '0;
    pkt[HDR_LSB +: HDR_W] = hdr;
    pkt[Y_LSB +: Y_W]     = y;
    pkt[KEY_LSB +: KEY_W] = s1_r;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= pkt;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_function_2.sv
// Directed bench for encrypt_function_2: vector table plus hand sequences
// for latency, backpressure, reseed, mid-flight reset and tag wrap.
module tb_encrypt_function_2;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        seed_load;
  logic [10:0] seed_val;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_data;

  encrypt_function_2 dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad = 0;

  logic [77:0] got_q[$];
  logic [77:0] exp_q[$];
  logic [59:0] exp_p[$];

  logic [10:0] m_lfsr;
  logic [5:0]  m_seq;

  function automatic logic [59:0] tb_mask(input logic [10:0] r);
    logic [59:0] b;
    for (int i = 0; i < 60; i++) begin
      if (i >= 49)      b[i] = r[i-49];
      else if (i >= 38) b[i] = r[i-38];
      else if (i >= 27) b[i] = ~r[i-27];
      else if (i >= 16) b[i] = ~r[i-16];
      else if (i >= 5)  b[i] = r[i-5];
      else              b[i] = r[i+6];
    end
    return b;
  endfunction

  // reference model, sampled mid-cycle when all handshakes are stable
  always @(negedge Clk) begin
    logic [60:0] ym;
    logic [5:0]  hm;
    if (Rst) begin
      m_lfsr = 11'h7FF;
      m_seq  = 6'd0;
    end else begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (in_valid && in_ready) begin
        ym = {1'b0, in_data} + {1'b0, tb_mask(m_lfsr)};
`ifdef ENC2_SEQ_TAG_EN
        hm = m_seq;
`else
        hm = 6'd0;
`endif
        exp_q.push_back({hm, ym, m_lfsr});
        exp_p.push_back(in_data);
        m_seq = m_seq + 6'd1;
      end
      if (seed_load)
        m_lfsr = (seed_val == 11'd0) ? 11'h7FF : seed_val;
      else if (in_valid && in_ready)
        m_lfsr = {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
    end
  end

  task automatic chk(input string name, input logic [95:0] got,
                     input logic [95:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    seed_load = 1'b0;
    seed_val  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    exp_p.delete();
    Rst = 1'b0;
  endtask

  task automatic send(input logic [59:0] p, input logic sl,
                      input logic [10:0] sv, output logic ok);
    logic rdy;
    int n;
    in_valid  = 1'b1;
    in_data   = p;
    seed_load = sl;
    seed_val  = sv;
    n = 0;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    ok = rdy;
    seed_load = 1'b0;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    int n;
    logic [60:0] yg;
    logic [59:0] pd;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_pkt%0d", tag, i), got_q[i], exp_q[i]);
      yg = got_q[i][71:11];
      pd = 60'(yg - {1'b0, tb_mask(got_q[i][10:0])});
      chk($sformatf("%s_dec%0d", tag, i), pd, exp_p[i]);
    end
  endtask

  typedef struct {
    logic [59:0] p;
    logic        sl;
    logic [10:0] sv;
    logic [10:0] key;
    logic        has_y;
    logic [60:0] y;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic ok;
    logic rdy;
    int acc;
    logic [77:0] held;
    logic [5:0] h63;
    logic [5:0] h64;

    tbl[0] = '{60'h0, 1'b0, 11'h0, 11'h7FF, 1'b1, 61'h0FFFFFC00000FFFF};
    tbl[1] = '{60'h0, 1'b0, 11'h0, 11'h7FE, 1'b0, 61'h0};
    tbl[2] = '{60'hABC, 1'b1, 11'h0, 11'h7FC, 1'b0, 61'h0};
    tbl[3] = '{60'hFFFFFFFFFFFFFFF, 1'b0, 11'h0, 11'h7FF, 1'b1,
               61'h1FFFFFC00000FFFE};
    tbl[4] = '{60'h123456789ABCDEF, 1'b0, 11'h0, 11'h7FE, 1'b0, 61'h0};
    tbl[5] = '{60'h555555555555555, 1'b1, 11'h001, 11'h7FC, 1'b0, 61'h0};
    tbl[6] = '{60'h0F0F0F0F0F0F0F0, 1'b0, 11'h0, 11'h001, 1'b0, 61'h0};
    tbl[7] = '{60'hFEDCBA987654321, 1'b0, 11'h0, 11'h002, 1'b0, 61'h0};

    // reset state
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 78'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // latency: out_valid two cycles after the accept cycle
    in_valid = 1'b1;
    in_data  = 60'h0;
    tick();
    idle();
    chk("lat_early", out_valid, 1'b0);
    tick();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data", out_data, {6'h0, 61'h0FFFFFC00000FFFF, 11'h7FF});
    drain_and_compare("lat");

    // vector table, back-to-back at full rate
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rdy = in_ready;
      send(tbl[i].p, tbl[i].sl, tbl[i].sv, ok);
      chk($sformatf("tbl_rate%0d", i), rdy, 1'b1);
    end
    idle();
    drain_and_compare("tbl");
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk($sformatf("tbl_key%0d", i), got_q[i][10:0], tbl[i].key);
      if (tbl[i].has_y)
        chk($sformatf("tbl_y%0d", i), got_q[i][71:11], tbl[i].y);
    end

    // backpressure: two words held, output stable
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 60'hA01;
    acc = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc++;
        in_data = in_data + 60'h1;
      end
      if (i == 2) held = out_data;
      if (i > 2) chk($sformatf("bp_stable%0d", i), out_data, held);
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) in_data = in_data + 60'h1;
    end
    idle();
    drain_and_compare("bp");

    // reset while two words are in flight
    do_reset();
    out_ready = 1'b0;
    send(60'h111, 1'b0, 11'h0, ok);
    send(60'h222, 1'b0, 11'h0, ok);
    idle();
    chk("mid_pre_valid", out_valid, 1'b1);
    #2;
    Rst = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_out_data", out_data, 78'h0);
    chk("mid_in_ready", in_ready, 1'b1);
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    exp_p.delete();
    Rst = 1'b0;
    out_ready = 1'b1;
    send(60'h5, 1'b0, 11'h0, ok);
    idle();
    drain_and_compare("mid");
    if (got_q.size() > 0)
      chk("mid_key", got_q[0][10:0], 11'h7FF);

    // 66 packets: header wraps 63 -> 0 when tagging is enabled
    do_reset();
    for (int i = 0; i < 66; i++) begin
      send(60'(i * 3 + 1), 1'b0, 11'h0, ok);
    end
    idle();
    drain_and_compare("wrap");
`ifdef ENC2_SEQ_TAG_EN
    h63 = 6'd63;
    h64 = 6'd0;
`else
    h63 = 6'd0;
    h64 = 6'd0;
`endif
    if (got_q.size() > 64) begin
      chk("wrap_h63", got_q[63][77:72], h63);
      chk("wrap_h64", got_q[64][77:72], h64);
      chk("wrap_h65", got_q[65][77:72], exp_q[65][77:72]);
    end else begin
      chk("wrap_len", got_q.size(), 66);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
